i2c_txn_arbiter: RTL

- Shares one i2c_controller instance among NREQ requesters: round-robin arbitration, loads the winner's address/data/mode, pulses the controller enable, waits for completion, returns the read byte.
- Sits between firmware/HW requesters (CPU register block, sensor poller) and i2c_controller; it is the sole driver of i2c_controller i_dev_addr/i_reg_addr/i_w_data/i_ctrl.

---
 rtl/i2c_txn_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one i2c_controller among NREQ requesters.
// Optional stuck-transaction abort is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter #(
  parameter int NREQ      = 3,
  parameter int SETUP_CYC = 2,
  parameter int TMO_CYC   = 200000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [7*NREQ-1:0] i_req_dev_addr,
  input  logic [8*NREQ-1:0] i_req_reg_addr,
  input  logic [8*NREQ-1:0] i_req_w_data,
  input  logic [NREQ-1:0]   i_req_rw,
  input  logic [2*NREQ-1:0] i_req_op_mode,
  output logic [NREQ-1:0]   o_gnt,
  output logic [NREQ-1:0]   o_done,
  output logic              o_err,
  output logic [7:0]        o_rd_data,
  output logic              o_busy,
  output logic [6:0]        o_dev_addr,
  output logic [7:0]        o_reg_addr,
  output logic [7:0]        o_w_data,
  output logic [31:0]       o_ctrl,
  input  logic [31:0]       i_status,
  input  logic [7:0]        i_rd_data
);

  localparam int IW = $clog2(NREQ);
  localparam int SW = $clog2(SETUP_CYC + 1);

  if (NREQ < 2 || NREQ > 8 || SETUP_CYC < 1 || TMO_CYC < 1) begin : g_param_check
    $error("i2c_txn_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DONE, S_DRAIN} state_t;

  state_t        state, state_d;
  logic [IW-1:0] ptr, idx, pick;
  logic          pick_vld;
  logic [SW-1:0] setup_cnt;
  logic          setup_last;
  logic          en_q, rw_q, fin_q, abort_q, fin_rise, timeout;
  logic [1:0]    op_q;
  logic          unused_status;

  logic [6:0] dev_arr [NREQ];
  logic [7:0] reg_arr [NREQ];
  logic [7:0] wd_arr  [NREQ];
  logic [1:0] op_arr  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign dev_arr[g] = i_req_dev_addr[7*g +: 7];
    assign reg_arr[g] = i_req_reg_addr[8*g +: 8];
    assign wd_arr[g]  = i_req_w_data[8*g +: 8];
    assign op_arr[g]  = i_req_op_mode[2*g +: 2];
  end

  assign unused_status = ^i_status[31:2];

  // First requesting index at or after ptr, wrapping once around.
  always_comb begin : rr_pick
    int unsigned k;
    k        = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = 32'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!pick_vld && i_req[IW'(k)]) begin
        pick     = IW'(k);
        pick_vld = 1'b1;
      end
    end
  end

  assign setup_last = (setup_cnt == SW'(SETUP_CYC - 1));

  always_comb begin
    state_d  = state;
    fin_rise = i_status[1] & ~fin_q;
    unique case (state)
      S_IDLE:  if (pick_vld) state_d = S_SETUP;
      S_SETUP: if (setup_last) state_d = S_RUN;
      S_RUN:   if (fin_rise || timeout) state_d = S_DONE;
      S_DONE:  state_d = abort_q ? S_IDLE : S_DRAIN;
      S_DRAIN: begin
        if (timeout) state_d = S_DONE;
        else if (i_status[0] && !i_status[1]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      idx        <= '0;
      o_gnt      <= '0;
      o_dev_addr <= '0;
      o_reg_addr <= '0;
      o_w_data   <= '0;
      o_rd_data  <= '0;
      rw_q       <= 1'b0;
      op_q       <= '0;
      en_q       <= 1'b0;
      fin_q      <= 1'b0;
      abort_q    <= 1'b0;
      setup_cnt  <= '0;
    end else begin
      state <= state_d;
      fin_q <= i_status[1];
      unique case (state)
        S_IDLE: if (pick_vld) begin
          idx        <= pick;
          o_gnt      <= NREQ'(1) << pick;
          o_dev_addr <= dev_arr[pick];
          o_reg_addr <= reg_arr[pick];
          o_w_data   <= wd_arr[pick];
          rw_q       <= i_req_rw[pick];
          op_q       <= op_arr[pick];
          setup_cnt  <= '0;
          abort_q    <= 1'b0;
        end
        S_SETUP: begin
          if (setup_last) en_q <= 1'b1;
          else setup_cnt <= setup_cnt + 1'b1;
        end
        S_RUN: begin
          if (fin_rise) begin
            en_q <= 1'b0;
            if (rw_q) o_rd_data <= i_rd_data;
          end else if (timeout) begin
            en_q    <= 1'b0;
            abort_q <= 1'b1;
          end
        end
        S_DONE: begin
          o_gnt <= '0;
          ptr   <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
        S_DRAIN: if (timeout) abort_q <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_active;

  assign tmo_active = (state == S_RUN) || (state == S_DRAIN);

  always_ff @(posedge i_clk) begin
    if (i_rst || !tmo_active || state_d != state) tmo_cnt <= '0;
    else tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout = tmo_active && (tmo_cnt == TW'(TMO_CYC - 1));
  assign o_err   = (state == S_DONE) && abort_q;
`else
  assign timeout = 1'b0;
  assign o_err   = 1'b0;
`endif

  assign o_done = (state == S_DONE) ? (NREQ'(1) << idx) : '0;
  assign o_busy = (state != S_IDLE);
  // Enable is gated by reset so the controller stops in the reset cycle itself.
  assign o_ctrl = {28'd0, op_q, rw_q, en_q & ~i_rst};

endmodule
